// File: rtl/life_pkg.sv
// Shared types and constants for the player-lives controller and its helpers.
package life_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ALIVE     = 3'd1,
    DYING     = 3'd2,
    RESPAWN   = 3'd3,
    GAME_OVER = 3'd4
  } life_state_t;

  localparam int LIVES_W = 2;

  // Largest of three frame budgets; sizes the shared frame counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the vsync-rate frame clock into the Clk domain and turns each
// rising edge into a single-cycle tick (latency 2-3 Clk cycles).
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic q1, q2, q3;

  // Two synchroniser flops plus one history flop for edge detection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
      q3 <= 1'b0;
    end else begin
      q1 <= frame_clk;
      q2 <= q1;
      q3 <= q2;
    end
  end

  assign tick = q2 & ~q3;

endmodule

// File: rtl/life_manager.sv
// Player-lives and death-sequencing controller: alive -> dying -> respawn
// (invulnerable, blinking) and a timed game-over hold. Feeds Beginning's
// is_life2 / dead_reset inputs and drives the lives HUD.
module life_manager
  import life_pkg::*;
#(
  parameter int NUM_LIVES       = 3,
  parameter int DYING_FRAMES    = 60,
  parameter int INVULN_FRAMES   = 120,
  parameter int GAMEOVER_FRAMES = 180,
  parameter int BLINK_SHIFT     = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic               game_on,
  input  logic               hit,
  output logic [LIVES_W-1:0] lives,
  output logic               is_life2,
  output logic               dead_reset,
  output logic               invincible,
  output logic               player_visible,
  output logic               game_over
);

  localparam int CNT_W = $clog2(max3(DYING_FRAMES, INVULN_FRAMES, GAMEOVER_FRAMES) + 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);
  localparam logic [CNT_W-1:0]   DYING_LAST = CNT_W'(DYING_FRAMES - 1);
  localparam logic [CNT_W-1:0]   INV_LAST   = CNT_W'(INVULN_FRAMES - 1);
  localparam logic [CNT_W-1:0]   GO_LAST    = CNT_W'(GAMEOVER_FRAMES - 1);

  life_state_t        state, state_nxt;
  logic [LIVES_W-1:0] lives_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               tick;

  frame_tick_sync u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  // State, lives and frame counter registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      lives <= LIVES_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      lives <= lives_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, lives bookkeeping and frame counter update.
  always_comb begin
    state_nxt = state;
    lives_nxt = lives;
    case (state)
      IDLE: begin
        lives_nxt = LIVES_INIT;
        if (game_on) state_nxt = ALIVE;
      end
      ALIVE: begin
        // A hit wins over a simultaneous game_on drop or frame tick.
        if (hit) begin
          if (lives > LIVES_W'(1)) begin
            lives_nxt = lives - LIVES_W'(1);
            state_nxt = DYING;
          end else begin
            lives_nxt = '0;
            state_nxt = GAME_OVER;
          end
        end else if (!game_on) begin
          state_nxt = IDLE;
        end
      end
      DYING: begin
        if (tick && cnt == DYING_LAST) state_nxt = RESPAWN;
      end
      RESPAWN: begin
        if (!game_on)                   state_nxt = IDLE;
        else if (tick && cnt == INV_LAST) state_nxt = ALIVE;
      end
      GAME_OVER: begin
        // game_on falls as a consequence of this state, so it is ignored.
        if (tick && cnt == GO_LAST) begin
          state_nxt = IDLE;
          lives_nxt = LIVES_INIT;
        end
      end
      default: begin
        state_nxt = IDLE;
        lives_nxt = LIVES_INIT;
      end
    endcase

    // Counter restarts on every transition and saturates rather than wraps.
    if (state_nxt != state)       cnt_nxt = '0;
    else if (tick && cnt != '1)   cnt_nxt = cnt + CNT_W'(1);
    else                          cnt_nxt = cnt;
  end

  // Outputs decoded purely from registered state, counter and lives.
  always_comb begin
    is_life2       = (lives != '0);
    dead_reset     = 1'b0;
    invincible     = 1'b0;
    player_visible = 1'b0;
    game_over      = 1'b0;
    case (state)
      IDLE, ALIVE: player_visible = 1'b1;
      DYING:       dead_reset     = 1'b1;
      RESPAWN: begin
        invincible     = 1'b1;
        player_visible = ~cnt[BLINK_SHIFT];
      end
      GAME_OVER: begin
        dead_reset = 1'b1;
        game_over  = 1'b1;
      end
      default:     player_visible = 1'b1;
    endcase
  end

endmodule

// File: doc/life_manager.md
Name: life_manager

Overview:
- Player-lives and death-sequencing controller. Sits directly upstream of the start-screen block (Beginning) and feeds its is_life2 and dead_reset inputs.
- Consumes game_on from Beginning and a collision "hit" level from the sprite/collision logic.
- Sequences alive → dying → respawn-invulnerable, and game-over hold. Drives the lives HUD and the player-blink enable.
- Everything runs in the 50 MHz Clk domain. frame_clk (VGA vsync) is synchronised and edge-detected into a one-cycle frame tick.

Parameters:
- NUM_LIVES, 3, lives loaded at game start (1..3).
- DYING_FRAMES, 60, frames spent in death animation.
- INVULN_FRAMES, 120, frames of post-respawn invulnerability.
- GAMEOVER_FRAMES, 180, frames the game-over hold lasts.
- BLINK_SHIFT, 3, player_visible toggles every 2^BLINK_SHIFT frames while invulnerable.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  asynchronous, active-high.
- frame_clk  in  1  vsync-rate frame clock, asynchronous to Clk.
- game_on  in  1  high while a game is running (from Beginning).
- hit  in  1  level; player overlaps an enemy or projectile this cycle.
- lives  out  2  remaining lives, including the current one.
- is_life2  out  1  high when lives != 0.
- dead_reset  out  1  high in DYING and GAME_OVER.
- invincible  out  1  high in RESPAWN.
- player_visible  out  1  player sprite draw enable.
- game_over  out  1  high in GAME_OVER.

Behaviour:
- Reset (async, any time): state=IDLE, lives=NUM_LIVES, frame counter=0, sync flops=0.
  - Outputs after reset: is_life2=1, dead_reset=0, invincible=0, player_visible=1, game_over=0.
- frame_tick:
  - frame_clk passes a 2-flop synchroniser plus a third flop for edge detect.
  - tick = q2 & ~q3, a one-Clk pulse per frame_clk rising edge.
  - Latency is 2-3 Clk cycles.
- All outputs are registered, or decoded only from registered state, counter and lives.
- Frame counter:
  - Width $clog2(max(DYING,INVULN,GAMEOVER)+1).
  - Cleared on every state transition.
  - Incremented on frame_tick. Never wraps inside a state.
- States:
  - IDLE: lives held at NUM_LIVES. When game_on=1 → ALIVE next cycle.
  - ALIVE: player_visible=1.
    - hit=1 and lives>1: lives-1, go to DYING.
    - hit=1 and lives==1: lives=0, go to GAME_OVER.
    - game_on=0 with no hit: go to IDLE.
  - DYING: dead_reset=1, player_visible=0. is_life2 stays 1, so Beginning is not reset. hit is ignored. When counter==DYING_FRAMES-1 and frame_tick → RESPAWN.
  - RESPAWN: invincible=1, hit is ignored.
    - player_visible = ~counter[BLINK_SHIFT].
    - When counter==INVULN_FRAMES-1 and frame_tick → ALIVE.
    - game_on=0 → IDLE.
  - GAME_OVER: dead_reset=1, is_life2=0, game_over=1, player_visible=0.
    - This asynchronously resets Beginning (game_on falls); game_on is ignored in this state.
    - When counter==GAMEOVER_FRAMES-1 and frame_tick → IDLE, lives=NUM_LIVES.
- Simultaneous events:
  - hit together with frame_tick in ALIVE: the hit is taken.
  - hit together with game_on=0 in ALIVE: the hit is taken and the death sequence completes.
- hit held high for many cycles counts as one life lost. Re-arming only occurs on the next ALIVE entry.
- lives never underflows; it saturates at 0.
- Illegal state encoding → IDLE.

Decomposition:
- Package life_pkg:
  - typedef enum logic [2:0] life_state_t {IDLE, ALIVE, DYING, RESPAWN, GAME_OVER}.
  - localparam LIVES_W=2.
- Sub-module frame_tick_sync (frame_clk, Clk, Reset → tick). It is reusable by the other frame-stepped blocks.

Test Plan:
- Reset mid-DYING → next Clk: lives=3, state IDLE, dead_reset=0, is_life2=1.
- game_on=1, one-cycle hit, 60 frame_clk edges → lives=2, dead_reset high for exactly 60 ticks, then invincible=1 for 120 ticks, then ALIVE.
- hit held high through DYING and RESPAWN → lives decrements only once per ALIVE entry. During RESPAWN, player_visible toggles every 8 ticks.
- Three deaths → on the third hit lives=0, is_life2=0, dead_reset=1, game_over=1. game_on dropping does not leave GAME_OVER early. After 180 ticks: IDLE, lives=3.
- hit and frame_tick in the same cycle in ALIVE → DYING entered and counter=0. game_on=0 in ALIVE with no hit → IDLE in 1 cycle, lives unchanged.
- frame_clk pulse asynchronous to Clk → exactly one tick, 2-3 Clk cycles after the rising edge.
